mem_arbiter: RTL

//  Sequences and shares the single-port 16-bit RAM between the instruction-fetch

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// LC-3 memory arbiter: shares one single-port RAM between instruction fetch (F) and load/store (D).
// Optional build macro ARB_RR_EN swaps fixed D>F priority for alternating priority on simultaneous requests.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          F_REQ,
    input  logic [AW-1:0] F_ADDR,
    output logic          F_GNT,
    output logic [DW-1:0] F_RDATA,
    output logic          F_DONE,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic [DW-1:0] D_RDATA,
    output logic          D_DONE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DIN,
    output logic          MEM_WE,
    output logic          MEM_CS,
    input  logic [DW-1:0] MEM_OUT,
    input  logic          MEM_READY,
    output logic          ERR
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] wait_cnt;
    logic          grant_d;
    logic          any_req;
    logic          timeout;
    logic          take;

    assign any_req = F_REQ | D_REQ;
    assign take    = (state == S_IDLE) && any_req;
    // Fires on the RD_TIMEOUT-th consecutive WAIT cycle without ready.
    assign timeout = (wait_cnt == CW'(RD_TIMEOUT - 1));

`ifdef ARB_RR_EN
    logic last_d;

    always_comb begin
        grant_d = D_REQ;
        if (D_REQ && F_REQ)
            grant_d = !last_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            last_d <= 1'b1;
        else if (take)
            last_d <= grant_d;
    end
`else
    assign grant_d = D_REQ;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = we_q ? S_DONE : S_WAIT;
            S_WAIT:  if (MEM_READY || timeout) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        MEM_CS   = 1'b0;
        MEM_WE   = 1'b0;
        MEM_ADDR = '0;
        MEM_DIN  = '0;
        F_GNT    = 1'b0;
        D_GNT    = 1'b0;
        F_DONE   = 1'b0;
        D_DONE   = 1'b0;
        if (state == S_ISSUE) begin
            MEM_CS   = 1'b1;
            MEM_WE   = we_q;
            MEM_ADDR = addr_q;
            MEM_DIN  = we_q ? wdata_q : '0;
        end
        if (state != S_IDLE) begin
            F_GNT = !owner_d;
            D_GNT = owner_d;
        end
        if (state == S_DONE) begin
            F_DONE = !owner_d;
            D_DONE = owner_d;
        end
    end

    // NOTE: every datapath register is reset so outputs read 0 as soon as RST_N falls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            owner_d <= grant_d;
            we_q    <= grant_d & D_WE;
            addr_q  <= grant_d ? D_ADDR : F_ADDR;
            wdata_q <= grant_d ? D_WDATA : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            wait_cnt <= '0;
        else if (state == S_WAIT && !MEM_READY && !timeout)
            wait_cnt <= wait_cnt + CW'(1);
        else
            wait_cnt <= '0;
    end

    // Read data is captured on the WAIT->DONE edge and held until that port's next read completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            F_RDATA <= '0;
            D_RDATA <= '0;
            ERR     <= 1'b0;
        end else if (state == S_WAIT && (MEM_READY || timeout)) begin
            if (owner_d)
                D_RDATA <= MEM_READY ? MEM_OUT : '0;
            else
                F_RDATA <= MEM_READY ? MEM_OUT : '0;
            if (!MEM_READY)
                ERR <= 1'b1;
        end
    end

endmodule
